// File: rtl/mac_pe_pkg.sv
// Shared definitions for the MAC processing element and its sequencers:
// datapath widths and the job sequencer state encoding.
package mac_pe_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 22;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_ACC    = 3'd4,
    ST_WAIT   = 3'd5,
    ST_HOLD   = 3'd6
  } mac_seq_state_t;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Read-side engine of the MAC job sequencer: pair counter, wrapping buffer
// address and the two-stage valid/data pipeline that feeds the MAC.
module mac_seq_addr_gen #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              rd_req,
  output logic              stream_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] w_rdata,
  input  logic [DATA_W-1:0] a_rdata,
  output logic              mac_data_valid,
  output logic [DATA_W-1:0] mac_weight,
  output logic [DATA_W-1:0] mac_activation
);

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              rd_d1;
  logic [LEN_W-1:0]  len_clamped;

  // Oversized jobs are truncated to the longest supported vector.
  assign len_clamped = (vec_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : vec_len;

  // All requested reads have been issued once the counter reaches the length.
  assign stream_done = (cnt_q == len_q);

  // Latch the job on load; advance the pair counter and address per read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
    end else if (load) begin
      len_q <= len_clamped;
      cnt_q <= '0;
      ptr_q <= base_addr;
    end else if (rd_req) begin
      cnt_q <= cnt_q + 1'b1;
      ptr_q <= ptr_q + 1'b1;  // natural wrap modulo 2^ADDR_W
    end
  end

  // Registered read strobe and address; address holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      mem_rd_en <= rd_req;
      if (rd_req) mem_addr <= ptr_q;
    end
  end

  // Buffer data arrives one cycle after the strobe; register it for the MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1          <= 1'b0;
      mac_data_valid <= 1'b0;
      mac_weight     <= '0;
      mac_activation <= '0;
    end else begin
      rd_d1          <= mem_rd_en;
      mac_data_valid <= rd_d1;
      if (rd_d1) begin
        mac_weight     <= w_rdata;
        mac_activation <= a_rdata;
      end
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for one 8-bit MAC PE: clear, stream pairs, drain, accumulate,
// wait for the MAC result and present it on a valid/ready result port.
// Optional WAIT watchdog: define MAC_SEQ_TIMEOUT_EN.
//
// Result handshake: res_valid rises only in HOLD and stays high with res_data
// and res_timeout stable until a cycle where res_valid && res_ready; that
// cycle is the transfer and the block returns to IDLE on the next edge.
module mac_seq_ctrl #(
  parameter int DATA_W  = mac_pe_pkg::DATA_W,
  parameter int ACC_W   = mac_pe_pkg::ACC_W,
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] w_rdata,
  input  logic [DATA_W-1:0] a_rdata,
  output logic              mac_en,
  output logic              mac_reset,
  output logic              mac_data_valid,
  output logic [DATA_W-1:0] mac_weight,
  output logic [DATA_W-1:0] mac_activation,
  output logic              mac_acc,
  input  logic              mac_output_valid,
  input  logic [ACC_W-1:0]  mac_output_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_timeout,
  output logic [2:0]        dbg_state
);

  import mac_pe_pkg::*;

  mac_seq_state_t state_q, state_d;
  logic           load;
  logic           rd_req;
  logic           stream_done;
  logic           drain_q;
  logic           wd_expire;

  assign load      = (state_q == ST_IDLE) && start && (vec_len != '0);
  assign rd_req    = (state_d == ST_STREAM);
  assign dbg_state = state_q;

  mac_seq_addr_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .vec_len       (vec_len),
    .base_addr     (base_addr),
    .rd_req        (rd_req),
    .stream_done   (stream_done),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .w_rdata       (w_rdata),
    .a_rdata       (a_rdata),
    .mac_data_valid(mac_data_valid),
    .mac_weight    (mac_weight),
    .mac_activation(mac_activation)
  );

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            res_timeout_q;

  assign wd_expire   = (wd_cnt_q == WD_W'(TIMEOUT - 1));
  assign res_timeout = res_timeout_q;

  // Watchdog counts WAIT cycles and restarts from zero on every WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wd_cnt_q <= '0;
    else if (state_q == ST_WAIT) wd_cnt_q <= wd_cnt_q + 1'b1;
    else                       wd_cnt_q <= '0;
  end
`else
  // Watchdog compiled out: WAIT never expires and no result is an abort.
  assign wd_expire   = 1'b0;
  assign res_timeout = (TIMEOUT < 0);
`endif

  // Next-state logic; the MAC result strobe only matters in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_STREAM;
      ST_STREAM: if (stream_done) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_q) state_d = ST_ACC;
      ST_ACC:    state_d = ST_WAIT;
      ST_WAIT:   if (mac_output_valid || wd_expire) state_d = ST_HOLD;
      ST_HOLD:   if (res_valid && res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register plus outputs registered from the next state so they line
  // up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy      <= 1'b0;
      mac_en    <= 1'b0;
      mac_reset <= 1'b0;
      mac_acc   <= 1'b0;
      res_valid <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != ST_IDLE);
      mac_en    <= (state_d != ST_IDLE);
      mac_reset <= (state_d == ST_CLEAR);
      mac_acc   <= (state_d == ST_ACC);
      res_valid <= (state_d == ST_HOLD);
      drain_q   <= (state_q == ST_DRAIN) ? ~drain_q : 1'b0;
    end
  end

  // Result capture in WAIT only; the value is held through HOLD and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
`ifdef MAC_SEQ_TIMEOUT_EN
      res_timeout_q <= 1'b0;
`endif
    end else if (state_q == ST_WAIT) begin
      if (mac_output_valid) begin
        res_data <= mac_output_result;
`ifdef MAC_SEQ_TIMEOUT_EN
        res_timeout_q <= 1'b0;
      end else if (wd_expire) begin
        res_data      <= '0;
        res_timeout_q <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural buffer pair and MAC PE.
module tb_mac_seq_ctrl;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 22;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 7;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  vec_len;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] a_rdata;
  logic              mac_en;
  logic              mac_reset;
  logic              mac_data_valid;
  logic [DATA_W-1:0] mac_weight;
  logic [DATA_W-1:0] mac_activation;
  logic              mac_acc;
  logic              mac_output_valid;
  logic [ACC_W-1:0]  mac_output_result;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              res_timeout;
  logic [2:0]        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  mac_seq_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .vec_len          (vec_len),
    .base_addr        (base_addr),
    .busy             (busy),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .w_rdata          (w_rdata),
    .a_rdata          (a_rdata),
    .mac_en           (mac_en),
    .mac_reset        (mac_reset),
    .mac_data_valid   (mac_data_valid),
    .mac_weight       (mac_weight),
    .mac_activation   (mac_activation),
    .mac_acc          (mac_acc),
    .mac_output_valid (mac_output_valid),
    .mac_output_result(mac_output_result),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_timeout      (res_timeout),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- buffers and MAC PE model ----------------
  logic [DATA_W-1:0]    w_mem [256];
  logic [DATA_W-1:0]    a_mem [256];
  logic signed [ACC_W-1:0] mac_accum;
  logic signed [15:0]   prod;
  logic                 mac_mute;

  assign prod = $signed(mac_weight) * $signed(mac_activation);

  always @(posedge clk) begin
    if (mem_rd_en) begin
      w_rdata <= w_mem[mem_addr];
      a_rdata <= a_mem[mem_addr];
    end else begin
      w_rdata <= 8'($urandom);
      a_rdata <= 8'($urandom);
    end
  end

  always @(posedge clk) begin
    if (mac_reset)           mac_accum <= '0;
    else if (mac_data_valid) mac_accum <= mac_accum + 22'(prod);
    mac_output_valid  <= mac_acc && !mac_mute;
    if (mac_acc) mac_output_result <= mac_accum;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Launch a job at the current negedge and follow it to the first IDLE cycle.
  // hold > 0 keeps res_ready low for that many extra HOLD cycles and pulses
  // start during HOLD.
  task automatic run_job(input string tag, input int vlen, input logic [7:0] base,
                         input int eff_len, input logic [21:0] exp_res,
                         input int exp_lat, input logic exp_to, input int hold);
    int n_rd, n_dv, n_acc, acc_cyc, rd_first, res_cyc, addr_bad;
    logic [7:0] exp_addr;
    logic busy1, clr1, held_ok;
    n_rd = 0; n_dv = 0; n_acc = 0; acc_cyc = -1; rd_first = -1;
    res_cyc = -1; addr_bad = 0; exp_addr = base; busy1 = 0; clr1 = 0;
    held_ok = 1'b1;
    res_ready = (hold == 0);
    start = 1'b1; vec_len = 7'(vlen); base_addr = base;
    @(posedge clk);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin busy1 = busy & mac_en; clr1 = mac_reset; end
      if (mem_rd_en) begin
        if (n_rd == 0) rd_first = c;
        if (mem_addr !== exp_addr) addr_bad++;
        exp_addr = exp_addr + 8'd1;
        n_rd++;
      end
      if (mac_data_valid) n_dv++;
      if (mac_acc) begin n_acc++; if (acc_cyc < 0) acc_cyc = c; end
      if (res_valid) begin res_cyc = c; break; end
    end
    check({tag, "_busy_c1"}, 32'(busy1), 1);
    check({tag, "_clear_c1"}, 32'(clr1), 1);
    check({tag, "_first_rd"}, rd_first, 2);
    check({tag, "_reads"}, n_rd, eff_len);
    check({tag, "_addr_errs"}, addr_bad, 0);
    check({tag, "_dv"}, n_dv, eff_len);
    check({tag, "_acc_cyc"}, acc_cyc, eff_len + 4);
    check({tag, "_acc_cnt"}, n_acc, 1);
    check({tag, "_latency"}, res_cyc, exp_lat);
    check({tag, "_res_data"}, 32'(res_data), 32'(exp_res));
    check({tag, "_timeout"}, 32'(res_timeout), 32'(exp_to));
    for (int h = 0; h < hold; h++) begin
      start = (h == 1); vec_len = 7'd3; base_addr = 8'h00;
      @(negedge clk);
      if (!(res_valid && busy && res_data == exp_res)) held_ok = 1'b0;
    end
    start = 1'b0;
    if (hold > 0) check({tag, "_held"}, 32'(held_ok), 1);
    res_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'({busy, res_valid, mac_en}), 0);
    check({tag, "_idle_data"}, 32'(res_data), 32'(exp_res));
  endtask

  // Global guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    for (int i = 0; i < 256; i++) begin w_mem[i] = 8'd1; a_mem[i] = 8'd1; end
    w_mem[8'h10] = 8'd1;      a_mem[8'h10] = 8'd5;
    w_mem[8'h11] = 8'(-2);    a_mem[8'h11] = 8'd6;
    w_mem[8'h12] = 8'd3;      a_mem[8'h12] = 8'(-7);
    w_mem[8'h13] = 8'd127;    a_mem[8'h13] = 8'(-128);
    w_mem[8'hFE] = 8'd2; w_mem[8'hFF] = 8'd3; w_mem[8'h00] = 8'd4; w_mem[8'h01] = 8'd5;
    w_mem[8'h20] = 8'd10;     a_mem[8'h20] = 8'd4;
    w_mem[8'h21] = 8'(-3);    a_mem[8'h21] = 8'd5;
    w_mem[8'h30] = 8'd7;      a_mem[8'h30] = 8'd9;
    w_mem[8'h31] = 8'(-8);    a_mem[8'h31] = 8'd2;
    mac_mute = 1'b0; mac_accum = '0; mac_output_valid = 1'b0; mac_output_result = '0;
    rst_n = 1'b0; start = 1'b0; vec_len = '0; base_addr = '0; res_ready = 1'b1;

    // Reset state
    #1;
    check("rst_ctrl", 32'({busy, mem_rd_en, mac_en, mac_reset, mac_data_valid,
                          mac_acc, res_valid, res_timeout}), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_pair", 32'({mac_weight, mac_activation}), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_state", 32'(dbg_state), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic job: 5 - 12 - 21 - 16256
    run_job("basic", 4, 8'h10, 4, 22'(-16284), 10, 1'b0, 0);
    // Back-to-back: address wrap FE, FF, 00, 01 -> 2+3+4+5
    run_job("wrap", 4, 8'hFE, 4, 22'd14, 10, 1'b0, 0);

    // Zero-length job is ignored
    seen = 1'b0;
    start = 1'b1; vec_len = 7'd0; base_addr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      seen = seen | busy | mem_rd_en | mac_reset | mac_en;
    end
    check("zero_len_idle", 32'(seen), 0);

    // Oversized job clamps to 64 pairs of 1*1
    run_job("len100", 100, 8'h40, 64, 22'd64, 70, 1'b0, 0);

    // Backpressure: 10*4 - 3*5
    run_job("bp", 2, 8'h20, 2, 22'd25, 8, 1'b0, 5);

    // Reset in the third STREAM cycle
    start = 1'b1; vec_len = 7'd4; base_addr = 8'h10;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin @(negedge clk); start = 1'b0; end
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 32'({busy, mem_rd_en, mac_en, mac_reset, mac_data_valid,
                             mac_acc, res_valid, res_timeout}), 0);
    check("midrst_data", 32'({mem_addr, mac_weight, mac_activation}), 0);
    check("midrst_res", 32'(res_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Fresh job after abort: 7*9 - 8*2
    run_job("post_rst", 2, 8'h30, 2, 22'd47, 8, 1'b0, 0);

`ifdef MAC_SEQ_TIMEOUT_EN
    // Watchdog: MAC silent, WAIT entered at cycle 6, abort visible at 6+32
    mac_mute = 1'b1;
    run_job("wdog", 1, 8'h50, 1, 22'd0, 38, 1'b1, 0);
    mac_mute = 1'b0;
    run_job("wdog_recover", 2, 8'h20, 2, 22'd25, 8, 1'b0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
